alu_word_sequencer: RTL and testbench
=====================================

Name: alu_word_sequencer

Overview:
- Multi-cycle controller that runs 8/16/24/32-bit operations on the shared 8-bit 74181-pair ALU, one byte per cycle, LSB first.
- Carry is chained between bytes; full-width result, final carry and whole-word zero are assembled in registers.
- Sits between the CPU control path (request side) and the ALU (driven combinationally), with valid/ready handshakes on both request and response.

Parameters:
- MAX_BYTES, 4, maximum operand width in bytes (1..4).
- LEN_W, $clog2(MAX_BYTES), width of the length field.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  = (state==IDLE).
- req_mode  in  1  ALU Mode for all bytes.
- req_sel  in  4  ALU Selector for all bytes.
- req_a  in  8*MAX_BYTES  operand A.
- req_b  in  8*MAX_BYTES  operand B.
- req_cin  in  1  carry into byte 0.
- req_len  in  LEN_W  byte count minus 1.
- alu_mode  out  1  to ALU Mode.
- alu_sel  out  4  to ALU Selector.
- alu_a  out  8  to ALU A.
- alu_b  out  8  to ALU B.
- alu_cin  out  1  to ALU CarryIn.
- alu_f  in  8  ALU F.
- alu_cout  in  1  ALU CarryOut.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_f  out  8*MAX_BYTES  result; bytes above len are 0.
- rsp_cout  out  1  carry out of the last active byte.
- rsp_zero  out  1  1 when all active result bytes are 0.
- busy  out  1  = (state!=IDLE).

Behaviour:
- States: IDLE, EXEC, DONE.
- Reset (async, immediate, including mid-EXEC or mid-DONE):
  - state=IDLE, idx=0, carry_r=0.
  - rsp_valid=0, rsp_f=0, rsp_cout=0, rsp_zero=0.
  - Captured operands cleared.
  - A pending response is discarded.
- IDLE:
  - req_ready=1; ALU driven with mode=1, sel=0, a=0, b=0, cin=0.
  - On req_valid: capture mode/sel/a/b/cin/len, clear rsp_f, set idx=0, zero_acc=1, go EXEC.
- EXEC: ALU inputs are combinational from registers.
  - alu_a = a_r[8*idx+:8], alu_b = b_r[8*idx+:8].
  - alu_cin = (idx==0) ? cin_r : carry_r.
  - At each edge: rsp_f[8*idx+:8] <= alu_f, carry_r <= alu_cout, zero_acc &= (alu_f==0).
  - If idx==len: go DONE, with rsp_valid=1, rsp_cout=alu_cout, rsp_zero=zero_acc&(alu_f==0). Otherwise idx++.
- Latency: req accept edge → rsp_valid high after len+1 further edges. 16-bit op: rsp_valid 2 cycles after acceptance.
- DONE:
  - Outputs held stable while rsp_ready=0; no new request is accepted.
  - On rsp_ready: rsp_valid<=0, go IDLE. rsp_f/cout/zero keep their values until the next acceptance.
- Throughput: one op per len+3 cycles minimum. No request/response overlap.
- ALU ZeroFlag output is ignored; zero is computed from F.
- Carry polarity belongs to the ALU; the controller passes carry unmodified.
- req_len > MAX_BYTES-1 cannot occur when MAX_BYTES is a power of 2; otherwise it is clamped to MAX_BYTES-1.

Decomposition:
- Package alu_seq_pkg holds:
  - state enum {IDLE, EXEC, DONE};
  - MAX_BYTES default;
  - req_t struct (mode, sel, a, b, cin, len).
- Sub-module alu_byte_slicer: combinational byte select of a_r/b_r by idx, plus carry mux.

Test Plan:
- Bench ALU stub: mode=0 → {cout,F} = A+B+cin; mode=1 → F=A^B, cout=0.
- 8-bit: len=0, A=0x12, B=0x34, cin=0 → rsp_f=0x00000046, cout=0, zero=0, rsp_valid 1 cycle after accept.
- 16-bit carry chain: len=1, A=0x00FF, B=0x0001 → byte0 cin=0, byte1 cin=1; rsp_f=0x0100, cout=0, zero=0.
- 32-bit wrap: len=3, A=0xFFFFFFFF, B=0x00000001 → rsp_f=0, cout=1, zero=1, rsp_valid 4 cycles after accept.
- Logic mode / backpressure: mode=1, len=1, A=B=0xA5A5, rsp_ready low 5 cycles → rsp_f=0, zero=1 held stable; req_ready=0 throughout; IDLE one cycle after rsp_ready.
- Reset mid-EXEC: assert rst at idx=1 of a len=3 op → same cycle state=IDLE, rsp_valid=0, rsp_f=0; next request completes correctly.

Source files
------------

// File: rtl/alu_word_sequencer_pkg.sv
// Shared types for the byte-serial ALU word sequencer: FSM states, the captured
// request record and small helpers.
package alu_seq_pkg;

    localparam int SEQ_MAX_BYTES = 4;
    localparam int SEQ_WORD_W    = 8 * SEQ_MAX_BYTES;
    localparam int SEQ_LEN_W     = (SEQ_MAX_BYTES > 1) ? $clog2(SEQ_MAX_BYTES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic                  mode;
        logic [3:0]            sel;
        logic [SEQ_WORD_W-1:0] a;
        logic [SEQ_WORD_W-1:0] b;
        logic                  cin;
        logic [SEQ_LEN_W-1:0]  len;
    } req_t;

    function automatic logic is_zero_byte(input logic [7:0] v);
        return (v == 8'h00);
    endfunction

endpackage

// File: rtl/alu_word_sequencer_if.sv
// Request, ALU and response signals between the CPU control path, the
// sequencer and the 8-bit ALU.
interface alu_word_sequencer_if #(
    parameter int MAX_BYTES = 4
);
    localparam int LEN_W  = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
    localparam int WORD_W = 8 * MAX_BYTES;

    logic              req_valid;
    logic              req_ready;
    logic              req_mode;
    logic [3:0]        req_sel;
    logic [WORD_W-1:0] req_a;
    logic [WORD_W-1:0] req_b;
    logic              req_cin;
    logic [LEN_W-1:0]  req_len;

    logic              alu_mode;
    logic [3:0]        alu_sel;
    logic [7:0]        alu_a;
    logic [7:0]        alu_b;
    logic              alu_cin;
    logic [7:0]        alu_f;
    logic              alu_cout;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [WORD_W-1:0] rsp_f;
    logic              rsp_cout;
    logic              rsp_zero;

    // Requester plus ALU side (testbench / surrounding datapath)
    modport master (
        output req_valid, req_mode, req_sel, req_a, req_b, req_cin, req_len,
        input  req_ready,
        input  alu_mode, alu_sel, alu_a, alu_b, alu_cin,
        output alu_f, alu_cout,
        input  rsp_valid, rsp_f, rsp_cout, rsp_zero,
        output rsp_ready
    );

    // Sequencer side
    modport slave (
        input  req_valid, req_mode, req_sel, req_a, req_b, req_cin, req_len,
        output req_ready,
        output alu_mode, alu_sel, alu_a, alu_b, alu_cin,
        input  alu_f, alu_cout,
        output rsp_valid, rsp_f, rsp_cout, rsp_zero,
        input  rsp_ready
    );

endinterface

// File: rtl/alu_word_sequencer_byte_slicer.sv
// Picks the active operand byte pair and the carry-in for the byte being
// executed; drives all zeros when the sequencer is not executing.
module alu_byte_slicer #(
    parameter int NBYTES = 4,
    parameter int LEN_W  = 2
) (
    input  logic                  i_active,
    input  logic [LEN_W-1:0]      i_idx,
    input  logic [8*NBYTES-1:0]   i_a,
    input  logic [8*NBYTES-1:0]   i_b,
    input  logic                  i_cin,
    input  logic                  i_carry,
    output logic [7:0]            o_a,
    output logic [7:0]            o_b,
    output logic                  o_cin
);

    logic [LEN_W+2:0] w_bit_base;

    assign w_bit_base = {i_idx, 3'b000};

    // Byte mux and carry chain: byte 0 takes the request carry, later bytes the previous ALU carry
    always_comb begin
        o_a   = 8'h00;
        o_b   = 8'h00;
        o_cin = 1'b0;
        if (i_active) begin
            o_a = i_a[w_bit_base +: 8];
            o_b = i_b[w_bit_base +: 8];
            if (i_idx == {LEN_W{1'b0}}) begin
                o_cin = i_cin;
            end else begin
                o_cin = i_carry;
            end
        end else begin
            o_a   = 8'h00;
            o_b   = 8'h00;
            o_cin = 1'b0;
        end
    end

endmodule

// File: rtl/alu_word_sequencer.sv
// Runs 8..32-bit operations on an 8-bit ALU one byte per cycle, LSB first,
// chaining carry and assembling the word result. MAX_BYTES <= SEQ_MAX_BYTES.
module alu_word_sequencer
    import alu_seq_pkg::*;
#(
    parameter int MAX_BYTES = SEQ_MAX_BYTES
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_word_sequencer_if.slave  bus,
    output logic                 busy
);

    localparam int LEN_W  = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
    localparam int WORD_W = 8 * MAX_BYTES;

    state_t             r_state;
    state_t             w_state_nxt;
    req_t               r_req;
    req_t               w_req;
    logic [LEN_W-1:0]   r_idx;
    logic               r_carry;
    logic               r_zero_acc;
    logic               r_rsp_valid;
    logic [WORD_W-1:0]  r_rsp_f;
    logic               r_rsp_cout;
    logic               r_rsp_zero;

    logic [LEN_W-1:0]   w_len;
    logic [LEN_W-1:0]   w_req_len;
    logic               w_last;
    logic               w_f_zero;
    logic [LEN_W+2:0]   w_bit_base;

    // A length field that can encode more than MAX_BYTES bytes is clamped
    generate
        if ((1 << LEN_W) == MAX_BYTES) begin : g_len_pow2
            assign w_len = bus.req_len;
        end else begin : g_len_clamp
            assign w_len = (bus.req_len > LEN_W'(MAX_BYTES - 1)) ? LEN_W'(MAX_BYTES - 1)
                                                                 : bus.req_len;
        end
    endgenerate

    assign w_req_len  = r_req.len[LEN_W-1:0];
    assign w_last     = (r_idx == w_req_len);
    assign w_f_zero   = is_zero_byte(bus.alu_f);
    assign w_bit_base = {r_idx, 3'b000};

    // Request record captured on acceptance
    always_comb begin
        w_req      = '0;
        w_req.mode = bus.req_mode;
        w_req.sel  = bus.req_sel;
        w_req.a    = SEQ_WORD_W'(bus.req_a);
        w_req.b    = SEQ_WORD_W'(bus.req_b);
        w_req.cin  = bus.req_cin;
        w_req.len  = SEQ_LEN_W'(w_len);
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (bus.req_valid) begin
                    w_state_nxt = EXEC;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            EXEC: begin
                if (w_last) begin
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = EXEC;
                end
            end
            DONE: begin
                if (bus.rsp_ready) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = DONE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Handshake status and ALU function; outside EXEC the ALU sees the idle pattern
    always_comb begin
        bus.req_ready = 1'b0;
        busy          = 1'b1;
        bus.alu_mode  = 1'b1;
        bus.alu_sel   = 4'h0;
        if (r_state == IDLE) begin
            bus.req_ready = 1'b1;
            busy          = 1'b0;
        end else begin
            bus.req_ready = 1'b0;
            busy          = 1'b1;
        end
        if (r_state == EXEC) begin
            bus.alu_mode = r_req.mode;
            bus.alu_sel  = r_req.sel;
        end else begin
            bus.alu_mode = 1'b1;
            bus.alu_sel  = 4'h0;
        end
    end

    alu_byte_slicer #(
        .NBYTES (MAX_BYTES),
        .LEN_W  (LEN_W)
    ) u_slicer (
        .i_active (r_state == EXEC),
        .i_idx    (r_idx),
        .i_a      (r_req.a[WORD_W-1:0]),
        .i_b      (r_req.b[WORD_W-1:0]),
        .i_cin    (r_req.cin),
        .i_carry  (r_carry),
        .o_a      (bus.alu_a),
        .o_b      (bus.alu_b),
        .o_cin    (bus.alu_cin)
    );

    // Capture, per-byte result assembly and response hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req       <= '0;
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_zero_acc  <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_f     <= '0;
            r_rsp_cout  <= 1'b0;
            r_rsp_zero  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.req_valid) begin
                        r_req      <= w_req;
                        r_rsp_f    <= '0;
                        r_idx      <= '0;
                        r_zero_acc <= 1'b1;
                    end
                end
                EXEC: begin
                    r_rsp_f[w_bit_base +: 8] <= bus.alu_f;
                    r_carry    <= bus.alu_cout;
                    r_zero_acc <= r_zero_acc & w_f_zero;
                    if (w_last) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_cout  <= bus.alu_cout;
                        r_rsp_zero  <= r_zero_acc & w_f_zero;
                    end else begin
                        r_idx <= r_idx + LEN_W'(1);
                    end
                end
                DONE: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: r_rsp_valid <= 1'b0;
            endcase
        end
    end

    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_f     = r_rsp_f;
    assign bus.rsp_cout  = r_rsp_cout;
    assign bus.rsp_zero  = r_rsp_zero;

endmodule

// File: tb/tb_alu_word_sequencer.sv
// Directed bench for alu_word_sequencer with an add/xor ALU stub, a
// transaction-level reference model and a per-cycle compare process.
module tb_alu_word_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    int   t_acc = 0;

    alu_word_sequencer_if #(.MAX_BYTES(4)) bus();

    alu_word_sequencer #(.MAX_BYTES(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ALU stub: mode 0 adds with carry, mode 1 is XOR with no carry
    always_comb begin
        if (bus.alu_mode == 1'b0) begin
            {bus.alu_cout, bus.alu_f} = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {8'h00, bus.alu_cin};
        end else begin
            bus.alu_f    = bus.alu_a ^ bus.alu_b;
            bus.alu_cout = 1'b0;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Whole-word result from plain arithmetic over the active bytes: {cout, f}
    function automatic logic [32:0] model_op(input logic mode, input logic [31:0] a,
                                             input logic [31:0] b, input logic cin, input int len);
        int          nb;
        logic [63:0] mask;
        logic [63:0] s;
        nb   = 8 * (len + 1);
        mask = (64'd1 << nb) - 64'd1;
        if (mode == 1'b0) begin
            s = (64'(a) & mask) + (64'(b) & mask) + 64'(cin);
            return {s[nb], 32'(s & mask)};
        end else begin
            s = 64'(a ^ b) & mask;
            return {1'b0, 32'(s)};
        end
    endfunction

    // Reference model: accepted -> result after len+1 edges -> held until consumed
    logic        m_busy, m_valid, m_mode, m_cin, m_cout, m_zero;
    logic [3:0]  m_sel;
    logic [31:0] m_a, m_b, m_f;
    int          m_len, m_cnt;
    logic [32:0] m_res;

    always_comb m_res = model_op(m_mode, m_a, m_b, m_cin, m_len);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0; m_valid <= 1'b0; m_cnt <= 0;
            m_f <= 32'h0; m_cout <= 1'b0; m_zero <= 1'b0;
            m_mode <= 1'b0; m_sel <= 4'h0; m_a <= 32'h0; m_b <= 32'h0; m_cin <= 1'b0; m_len <= 0;
        end else if (!m_busy) begin
            if (bus.req_valid) begin
                m_busy <= 1'b1; m_cnt <= int'(bus.req_len) + 1;
                m_mode <= bus.req_mode; m_sel <= bus.req_sel; m_a <= bus.req_a;
                m_b <= bus.req_b; m_cin <= bus.req_cin; m_len <= int'(bus.req_len);
                m_f <= 32'h0;
            end
        end else if (!m_valid) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                m_valid <= 1'b1;
                m_f     <= m_res[31:0];
                m_cout  <= m_res[32];
                m_zero  <= (m_res[31:0] == 32'h0);
            end
        end else if (bus.rsp_ready) begin
            m_valid <= 1'b0;
            m_busy  <= 1'b0;
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (!rst) begin
            check("req_ready", 64'(bus.req_ready), 64'(!m_busy));
            check("busy", 64'(busy), 64'(m_busy));
            check("rsp_valid", 64'(bus.rsp_valid), 64'(m_valid));
            if (!m_busy || m_valid) begin
                check("rsp_f", 64'(bus.rsp_f), 64'(m_f));
                check("rsp_cout", 64'(bus.rsp_cout), 64'(m_cout));
                check("rsp_zero", 64'(bus.rsp_zero), 64'(m_zero));
            end
            if (!m_busy) begin
                check("alu_idle", 64'({bus.alu_mode, bus.alu_sel, bus.alu_a, bus.alu_b, bus.alu_cin}),
                      64'({1'b1, 4'h0, 8'h00, 8'h00, 1'b0}));
            end
            if (m_busy && !m_valid) begin
                check("alu_fn", 64'({bus.alu_mode, bus.alu_sel}), 64'({m_mode, m_sel}));
            end
        end
    end

    task automatic send(input logic mode, input logic [3:0] sel, input logic [31:0] a,
                        input logic [31:0] b, input logic cin, input logic [1:0] len);
        @(posedge clk); #2;
        bus.req_valid = 1'b1; bus.req_mode = mode; bus.req_sel = sel;
        bus.req_a = a; bus.req_b = b; bus.req_cin = cin; bus.req_len = len;
        @(posedge clk); #2;
        t_acc = cyc;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string name, input int exp_lat);
        int guard = 0;
        while (!bus.rsp_valid && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        check({name, "_latency"}, 64'(bus.rsp_valid ? cyc - t_acc : -1), 64'(exp_lat));
    endtask

    task automatic check_rsp(input string name, input logic [31:0] f, input logic cout, input logic zero);
        check({name, "_f"}, 64'(bus.rsp_f), 64'(f));
        check({name, "_cout"}, 64'(bus.rsp_cout), 64'(cout));
        check({name, "_zero"}, 64'(bus.rsp_zero), 64'(zero));
    endtask

    task automatic recv(input string name, input int hold, input logic [31:0] f);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({name, "_hold"}, 64'({bus.rsp_valid, bus.req_ready, bus.rsp_f}), 64'({1'b1, 1'b0, f}));
        end
        #1 bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        check({name, "_idle_after"}, 64'({bus.req_ready, bus.rsp_valid}), 64'({1'b1, 1'b0}));
        bus.rsp_ready = 1'b0;
    endtask

    task automatic run(input string name, input logic mode, input logic [31:0] a, input logic [31:0] b,
                       input logic cin, input logic [1:0] len, input logic [31:0] f,
                       input logic cout, input logic zero, input int hold);
        send(mode, 4'h9, a, b, cin, len);
        wait_rsp(name, int'(len) + 1);
        check_rsp(name, f, cout, zero);
        recv(name, hold, f);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.req_valid = 1'b0; bus.req_mode = 1'b0; bus.req_sel = 4'h0;
        bus.req_a = 32'h0; bus.req_b = 32'h0; bus.req_cin = 1'b0; bus.req_len = 2'd0;
        bus.rsp_ready = 1'b0;
        #23 rst = 1'b0;
        @(negedge clk);
        check("reset_state", 64'({bus.req_ready, busy, bus.rsp_valid, bus.rsp_f, bus.rsp_cout, bus.rsp_zero}),
              64'({1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0}));

        run("add8", 1'b0, 32'h00000012, 32'h00000034, 1'b0, 2'd0, 32'h00000046, 1'b0, 1'b0, 0);

        // 16-bit carry chain, watching the carry handed between bytes
        send(1'b0, 4'h9, 32'h000000FF, 32'h00000001, 1'b0, 2'd1);
        #1 check("chain_byte0", 64'({bus.alu_a, bus.alu_b, bus.alu_cin}), 64'({8'hFF, 8'h01, 1'b0}));
        @(posedge clk); #1;
        check("chain_byte1", 64'({bus.alu_a, bus.alu_b, bus.alu_cin}), 64'({8'h00, 8'h00, 1'b1}));
        wait_rsp("add16", 2);
        check_rsp("add16", 32'h00000100, 1'b0, 1'b0);
        recv("add16", 0, 32'h00000100);

        run("wrap32", 1'b0, 32'hFFFFFFFF, 32'h00000001, 1'b0, 2'd3, 32'h00000000, 1'b1, 1'b1, 0);
        run("xor16_bp", 1'b1, 32'h0000A5A5, 32'h0000A5A5, 1'b0, 2'd1, 32'h00000000, 1'b0, 1'b1, 5);
        run("xor16", 1'b1, 32'h0000F0F0, 32'h00000FF0, 1'b0, 2'd1, 32'h0000FF00, 1'b0, 1'b0, 1);
        run("add32", 1'b0, 32'h12345678, 32'h11111111, 1'b0, 2'd3, 32'h23456789, 1'b0, 1'b0, 0);
        run("add8_hi", 1'b0, 32'hFFFFFF01, 32'h000000FF, 1'b0, 2'd0, 32'h00000000, 1'b1, 1'b1, 2);

        // Reset while executing byte 1 of a 32-bit operation
        send(1'b0, 4'h9, 32'h11223344, 32'h01010101, 1'b0, 2'd3);
        @(posedge clk); #2;
        rst = 1'b1;
        #1 check("reset_mid_exec", 64'({bus.req_ready, busy, bus.rsp_valid, bus.rsp_f}),
                 64'({1'b1, 1'b0, 1'b0, 32'h0}));
        #4 rst = 1'b0;

        run("add24_after_rst", 1'b0, 32'h00123456, 32'h00FEDCBA, 1'b1, 2'd2, 32'h00111111, 1'b1, 1'b0, 0);

        repeat (3) @(posedge clk);
        #1 $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
